// File: rtl/tanh_golden_checker_pkg.sv
// Shared definitions for the tanh/sigmoid golden checkers.
//   - fixed-point word format used by the activation units
//   - FSM state encoding for the checker sequencer
package tanh_golden_checker_pkg;

    // Signed two's-complement word: 1 sign, FX_INT_BITS integer, FX_FRAC_BITS fraction.
    localparam int FX_BITWIDTH  = 18;
    localparam int FX_INT_BITS  = 2;
    localparam int FX_FRAC_BITS = FX_BITWIDTH - 1 - FX_INT_BITS;

    localparam logic [2:0] ENC_IDLE  = 3'd0;
    localparam logic [2:0] ENC_FETCH = 3'd1;
    localparam logic [2:0] ENC_DRIVE = 3'd2;
    localparam logic [2:0] ENC_WAIT  = 3'd3;
    localparam logic [2:0] ENC_CHECK = 3'd4;
    localparam logic [2:0] ENC_DONE  = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE  = ENC_IDLE,
        ST_FETCH = ENC_FETCH,
        ST_DRIVE = ENC_DRIVE,
        ST_WAIT  = ENC_WAIT,
        ST_CHECK = ENC_CHECK,
        ST_DONE  = ENC_DONE
    } state_t;

    // Integer value expressed in the activation fixed-point format.
    function automatic logic [FX_BITWIDTH-1:0] fx_from_int(input int value);
        return FX_BITWIDTH'(value <<< FX_FRAC_BITS);
    endfunction

endpackage

// File: rtl/tanh_golden_checker_abs_diff.sv
// Combinational |a - b| for two signed words.
//   a, b     : signed two's-complement operands, WIDTH bits
//   abs_val  : unsigned magnitude of a - b, WIDTH bits
// The subtract is done one bit wider so the full range difference
// (max positive minus min negative = 2^WIDTH - 1) never overflows.
module tanh_golden_checker_abs_diff #(
    parameter int WIDTH = 18
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] abs_val
);

    logic [WIDTH:0] diff;

    assign diff    = {a[WIDTH-1], a} - {b[WIDTH-1], b};
    assign abs_val = diff[WIDTH] ? WIDTH'(-diff) : WIDTH'(diff);

endmodule

// File: rtl/tanh_golden_checker.sv
// On-chip golden checker for the tanh unit.
// Walks paired input/golden ROMs, drives each input on the tanh operand,
// waits DUT_LATENCY cycles, compares the result against the golden word
// within TOLERANCE and accumulates statistics for bring-up.
//   clock, reset       : clock, synchronous active-high reset
//   start              : pulse that begins a run (accepted in IDLE/DONE)
//   rom_addr           : shared address to input and golden ROMs
//   rom_input/golden   : ROM data, valid one cycle after rom_addr
//   operand / result   : tanh unit operand (registered) and result
//   busy / done / pass : run status; pass valid while done
//   error_count        : saturating mismatch count
//   max_abs_error      : largest |result - golden| seen
//   first_fail_*       : index of the first mismatching sample
//
// state | meaning
// IDLE  | waiting for start after reset
// FETCH | rom_addr presented, ROM data arrives next cycle
// DRIVE | ROM data captured into operand and golden latch
// WAIT  | latency down-counter running
// CHECK | result compared, statistics updated, advance index
// DONE  | run complete, statistics held
module tanh_golden_checker
    import tanh_golden_checker_pkg::*;
#(
    parameter int BITWIDTH    = FX_BITWIDTH,
    parameter int MAX_SAMPLES = 40961,
    parameter int ADDR_WIDTH  = 16,
    parameter int CNT_WIDTH   = 16,
    parameter int DUT_LATENCY = 2,
    parameter int TOLERANCE   = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [BITWIDTH-1:0]   rom_input,
    input  logic [BITWIDTH-1:0]   rom_golden,
    output logic [BITWIDTH-1:0]   operand,
    input  logic [BITWIDTH-1:0]   result,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [CNT_WIDTH-1:0]  error_count,
    output logic [BITWIDTH-1:0]   max_abs_error,
    output logic                  first_fail_valid,
    output logic [ADDR_WIDTH-1:0] first_fail_index
);

    localparam int                    WAIT_W     = (DUT_LATENCY > 1) ? $clog2(DUT_LATENCY) : 1;
    localparam logic [WAIT_W-1:0]     WAIT_LOAD  = WAIT_W'(DUT_LATENCY - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_INDEX = ADDR_WIDTH'(MAX_SAMPLES - 1);
    localparam logic [BITWIDTH-1:0]   TOL        = BITWIDTH'(TOLERANCE);

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] index;
    logic [WAIT_W-1:0]     wait_cnt;
    logic [BITWIDTH-1:0]   golden_q;
    logic [BITWIDTH-1:0]   abs_err;
    logic                  mismatch;
    logic                  last_sample;

    tanh_golden_checker_abs_diff #(
        .WIDTH (BITWIDTH)
    ) u_abs_diff (
        .a       (result),
        .b       (golden_q),
        .abs_val (abs_err)
    );

    assign mismatch    = (abs_err > TOL);
    assign last_sample = (index == LAST_INDEX);

    assign busy = (state == ST_FETCH) || (state == ST_DRIVE) ||
                  (state == ST_WAIT)  || (state == ST_CHECK);
    assign done = (state == ST_DONE);
    assign pass = done && (error_count == '0);

    always_ff @(posedge clock) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE, ST_DONE: if (start) state_nxt = ST_FETCH;
            ST_FETCH:         state_nxt = ST_DRIVE;
            ST_DRIVE:         state_nxt = ST_WAIT;
            ST_WAIT:          if (wait_cnt == '0) state_nxt = ST_CHECK;
            ST_CHECK:         state_nxt = last_sample ? ST_DONE : ST_FETCH;
            default:          state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            index            <= '0;
            rom_addr         <= '0;
            wait_cnt         <= '0;
            golden_q         <= '0;
            operand          <= '0;
            error_count      <= '0;
            max_abs_error    <= '0;
            first_fail_valid <= 1'b0;
            first_fail_index <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        index            <= '0;
                        rom_addr         <= '0;
                        error_count      <= '0;
                        max_abs_error    <= '0;
                        first_fail_valid <= 1'b0;
                        first_fail_index <= '0;
                    end
                end
                ST_DRIVE: begin
                    operand  <= rom_input;
                    golden_q <= rom_golden;
                    wait_cnt <= WAIT_LOAD;
                end
                ST_WAIT: begin
                    if (wait_cnt != '0) wait_cnt <= wait_cnt - 1'b1;
                end
                ST_CHECK: begin
                    if (mismatch) begin
                        if (error_count != '1) error_count <= error_count + 1'b1;
                        if (!first_fail_valid) begin
                            first_fail_valid <= 1'b1;
                            first_fail_index <= index;
                        end
                    end
                    if (abs_err > max_abs_error) max_abs_error <= abs_err;
                    // rom_addr follows index so it is already valid on FETCH entry.
                    if (!last_sample) begin
                        index    <= index + 1'b1;
                        rom_addr <= index + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/tanh_golden_checker.md
Name: tanh_golden_checker

Overview:
- On-chip consumer of the tanh unit's output stream, and the hardware counterpart of the software stimulus/capture flow.
- Reads paired input/golden words from external synchronous ROMs and drives each input on the tanh operand port.
- Waits the DUT latency, then compares the tanh result against the golden word within a tolerance.
- Accumulates pass/fail statistics for FPGA bring-up, where no simulator or file dump is available.

Parameters:
- BITWIDTH, 18, width of operand/result/golden words (signed fixed point, two's complement).
- MAX_SAMPLES, 40961, number of ROM entries checked per run (indices 0..MAX_SAMPLES-1).
- ADDR_WIDTH, 16, ROM address and sample-index width; must satisfy 2^ADDR_WIDTH >= MAX_SAMPLES.
- CNT_WIDTH, 16, error counter width.
- DUT_LATENCY, 2, clock cycles from operand register update to valid result; must be >= 1.
- TOLERANCE, 0, maximum allowed |result - golden| in LSBs that still counts as a match.

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse that begins a run.
- rom_addr  out  ADDR_WIDTH  shared address to the input ROM and golden ROM.
- rom_input  in  BITWIDTH  input ROM data, valid one cycle after rom_addr.
- rom_golden  in  BITWIDTH  golden ROM data, valid one cycle after rom_addr.
- operand  out  BITWIDTH  drives tanh operand (registered).
- result  in  BITWIDTH  tanh result.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  high after the last compare; stays high until the next start or reset.
- pass  out  1  valid when done=1: 1 iff error_count==0.
- error_count  out  CNT_WIDTH  number of mismatching samples; saturates at all-ones.
- max_abs_error  out  BITWIDTH  largest |result - golden| seen, unsigned.
- first_fail_valid  out  1  set at the first mismatch.
- first_fail_index  out  ADDR_WIDTH  sample index of the first mismatch.

Behaviour:
- Reset: all outputs 0; FSM enters IDLE; internal index, wait counter and golden latch cleared. Reset in any state aborts the run.
- FSM states: IDLE, FETCH, DRIVE, WAIT, CHECK, DONE.
- IDLE: start=1 -> FETCH with index=0; statistics and first_fail_* cleared.
- DONE: start=1 likewise restarts and clears statistics and done.
- Busy states: start is ignored in FETCH, DRIVE, WAIT and CHECK.
- FETCH: rom_addr=index (registered, updated on entry). Next cycle -> DRIVE.
- DRIVE: operand<=rom_input; golden_q<=rom_golden; wait counter<=DUT_LATENCY-1. -> WAIT.
- WAIT: when the counter reaches 0 -> CHECK, otherwise decrement. The result is sampled in CHECK, exactly DUT_LATENCY cycles after the operand edge.
- CHECK: compute diff = sign-extended (BITWIDTH+1)-bit result - golden_q, abs_err = |diff| (fits BITWIDTH unsigned). Then:
  - Mismatch iff abs_err > TOLERANCE: error_count increments, saturating.
  - On the first mismatch only, first_fail_valid<=1 and first_fail_index<=index.
  - If abs_err > max_abs_error, update max_abs_error.
  - If index==MAX_SAMPLES-1 -> DONE, otherwise index+1 -> FETCH.
- Throughput: DUT_LATENCY+3 cycles per sample (5 at default). Total run length = MAX_SAMPLES*(DUT_LATENCY+3) cycles from start to done.
- operand holds its last value after DONE; it is never driven with X.
- busy=1 in FETCH/DRIVE/WAIT/CHECK; done=1 only in DONE; pass is combinational from done and error_count.
- Boundaries:
  - MAX_SAMPLES=1: a single sample, then DONE.
  - Index wrap cannot occur given the parameter constraint.
  - A start coincident with reset is ignored (reset wins).

Decomposition:
- Shared package holds BITWIDTH=18 and the fixed-point format constants used by tanh/sigmoid, plus the FSM state encoding localparams.
- One natural sub-module: abs_diff, a combinational signed subtract plus absolute value, reusable by future sigmoid checkers.
- The FSM, counters and statistics stay in the top module.

Test Plan:
- Setup for all scenarios: MAX_SAMPLES=4, DUT_LATENCY=2, TOLERANCE=0, with a bench DUT model that delays operand by 2 registers.
- Identity pass: ROMs equal ({0x00000,0x00100,0x3FF00,0x1FFFF}) -> done after 20 cycles, pass=1, error_count=0, max_abs_error=0, first_fail_valid=0.
- Single mismatch: golden[2]=0x3FF03 -> error_count=1, first_fail_index=2, max_abs_error=3, pass=0.
- Tolerance: same data with TOLERANCE=3 -> pass=1, max_abs_error=3. With TOLERANCE=2 -> error_count=1.
- Extreme sign difference: result 0x1FFFF vs golden 0x20000 -> abs_err=0x3FFFF, max_abs_error=0x3FFFF with no overflow.
- Reset mid-run: assert reset in WAIT of sample 1 -> next cycle all outputs 0, IDLE. A subsequent start completes a clean run with pass=1.
- Start handling: start pulsed while busy -> no effect, done timing unchanged. Start in DONE -> statistics cleared, a second identical run gives identical results.
